rf_writeback: RTL

//  Write side of the 32x32 register file: merges single-cycle ALU results and

---
 rtl/rf_writeback_if.sv | 39 +++
 rtl/rf_writeback.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rf_writeback_if.sv
// Bundle of the ALU/LSU result ports, the issue port and the RF write port
// of the register-file write-back block.
interface rf_writeback_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     rd_busy;
  logic [LW-1:0]   fifo_level;

  // Pipeline side: produces results and issue info, observes RF writes.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd,
    input  lsu_ready, rf_wen, rf_waddr, rf_wdata, rd_busy, fifo_level
  );

  // Write-back block side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd,
    output lsu_ready, rf_wen, rf_waddr, rf_wdata, rd_busy, fifo_level
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write-back arbiter: ALU results win the single write port,
// load results that collide are queued in a small FIFO and drain in order.
// A busy scoreboard marks destinations that are issued but not yet written.
module rf_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  rf_writeback_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  res_t            fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_r;
  logic [AW:0]     rd_ptr_r;
  logic [AW:0]     level_s;
  logic            full_s;
  logic            empty_s;
  logic            lsu_fire_s;
  logic            push_s;
  logic            pop_s;
  logic            sel_valid_s;
  res_t            sel_s;
  res_t            lsu_res_s;
  logic            rf_wen_r;
  logic [4:0]      rf_waddr_r;
  logic [XLEN-1:0] rf_wdata_r;
  logic [31:0]     rd_busy_r;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     busy_nxt_s;

  // Extra pointer MSB distinguishes full from empty, so level never wraps.
  assign level_s    = wr_ptr_r - rd_ptr_r;
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign lsu_fire_s = bus.lsu_valid & ~full_s;
  assign lsu_res_s  = '{rd: bus.lsu_rd, data: bus.lsu_data};

  // Fixed-priority selection of the write-port source and FIFO push/pop.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_s       = '0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (bus.alu_valid) begin
      sel_valid_s = 1'b1;
      sel_s       = '{rd: bus.alu_rd, data: bus.alu_data};
      push_s      = lsu_fire_s;
    end else if (!empty_s) begin
      sel_valid_s = 1'b1;
      sel_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
      pop_s       = 1'b1;
      push_s      = lsu_fire_s;
    end else if (lsu_fire_s) begin
      sel_valid_s = 1'b1;
      sel_s       = lsu_res_s;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Load-result FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[AW-1:0]] <= lsu_res_s;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Registered RF write port; x0 results are consumed without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= '0;
    end else if (sel_valid_s && (sel_s.rd != 5'd0)) begin
      rf_wen_r   <= 1'b1;
      rf_waddr_r <= sel_s.rd;
      rf_wdata_r <= sel_s.data;
    end else begin
      rf_wen_r   <= 1'b0;
    end
  end

  // Scoreboard: a write ending this cycle clears, an issue sets (set wins).
  assign set_mask_s = (bus.iss_valid && (bus.iss_rd != 5'd0)) ?
                      (32'd1 << bus.iss_rd) : 32'd0;
  assign clr_mask_s = rf_wen_r ? (32'd1 << rf_waddr_r) : 32'd0;
  assign busy_nxt_s = ((rd_busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy_r <= 32'd0;
    end else begin
      rd_busy_r <= busy_nxt_s;
    end
  end

  assign bus.lsu_ready  = ~full_s;
  assign bus.rf_wen     = rf_wen_r;
  assign bus.rf_waddr   = rf_waddr_r;
  assign bus.rf_wdata   = rf_wdata_r;
  assign bus.rd_busy    = rd_busy_r;
  assign bus.fifo_level = level_s;
endmodule
